// File: rtl/dac_pattern_gen_if.sv
// DAC sample stream: packed multi-channel sample word with a valid/ready handshake.
// The pattern generator drives the master side, the SPI DAC interface the slave side.
interface dac_pattern_gen_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 16
);
   logic [NUM_CH*DATA_W-1:0] dac_data;
   logic                     dac_valid;
   logic                     dac_ready;

   modport master (
      output dac_data,
      output dac_valid,
      input  dac_ready
   );

   modport slave (
      input  dac_data,
      input  dac_valid,
      output dac_ready
   );
endinterface

// File: rtl/dac_pattern_gen.sv
// Multi-channel DAC pattern source. A programmable tick divider paces sample
// generation; each tick produces one waveform value (static, sawtooth,
// triangle, square or mid-scale) which is fanned out to all channels with a
// per-channel offset and offered downstream through valid/ready. Ticks that
// arrive while an unconsumed sample is still pending are dropped and counted.
module dac_pattern_gen #(
   parameter int                 NUM_CH    = 4,
   parameter int                 DATA_W    = 16,
   parameter int                 DIV_W     = 16,
   parameter logic [DATA_W-1:0]  CH_OFFSET = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [2:0]            mode,
   input  logic [DATA_W-1:0]     level,
   input  logic [DATA_W-1:0]     step,
   input  logic [DIV_W-1:0]      div,
   dac_pattern_gen_if.master     dac_if,
   output logic [7:0]            overrun_cnt
);

   // Waveform select codes; 6 and 7 fall through to the zero output.
   localparam logic [2:0] MODE_ZERO   = 3'd0;
   localparam logic [2:0] MODE_LEVEL  = 3'd1;
   localparam logic [2:0] MODE_SAW    = 3'd2;
   localparam logic [2:0] MODE_TRI    = 3'd3;
   localparam logic [2:0] MODE_SQUARE = 3'd4;
   localparam logic [2:0] MODE_MID    = 3'd5;

   localparam logic [DATA_W-1:0] FULL_SCALE = '1;
   localparam logic [DATA_W-1:0] MID_SCALE  = {1'b1, {(DATA_W-1){1'b0}}};

   // Triangle direction; reset and mode changes always restart going up.
   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   // Registered state and its next values
   logic [DIV_W-1:0]   cnt_reg,    cnt_next;
   logic [2:0]         mode_q_reg, mode_q_next;
   logic [DATA_W-1:0]  acc_reg,    acc_next;
   dir_t               dir_reg,    dir_next;
   logic               sq_reg,     sq_next;
   logic               valid_reg,  valid_next;
   logic [7:0]         ovr_reg,    ovr_next;
   logic [DATA_W-1:0]  data_reg [NUM_CH];

   // Per-tick waveform value and the state it would advance to
   logic [DATA_W-1:0]  shape_val;
   logic [DATA_W-1:0]  acc_adv;
   dir_t               dir_adv;
   logic               sq_adv;

   // Control decode
   logic mode_change;
   logic cnt_at_div;
   logic tick;
   logic handshake;
   logic accept;
   logic drop;

   assign mode_change = (mode != mode_q_reg);
   assign cnt_at_div  = (cnt_reg == div);
   // A mode change restarts the period, so it never coincides with a tick.
   assign tick        = en && !mode_change && cnt_at_div;
   assign handshake   = valid_reg && dac_if.dac_ready;
   // The pending sample is either absent or leaving this very cycle.
   assign accept      = tick && (!valid_reg || dac_if.dac_ready);
   assign drop        = tick && valid_reg && !dac_if.dac_ready;

   // Waveform shape for the current accumulator and its advance rule.
   always_comb begin
      shape_val = '0;
      acc_adv   = acc_reg;
      dir_adv   = dir_reg;
      sq_adv    = sq_reg;
      case (mode_q_reg)
         MODE_LEVEL: begin
            shape_val = level;
         end
         MODE_SAW: begin
            shape_val = acc_reg;
            acc_adv   = acc_reg + step;
         end
         MODE_TRI: begin
            shape_val = acc_reg;
            if (dir_reg == DIR_UP) begin
               // Clamp at full scale instead of wrapping, then turn around.
               if (acc_reg > (FULL_SCALE - step)) begin
                  acc_adv = FULL_SCALE;
                  dir_adv = DIR_DOWN;
               end else begin
                  acc_adv = acc_reg + step;
               end
            end else begin
               // Clamp at zero instead of wrapping, then turn around.
               if (acc_reg < step) begin
                  acc_adv = '0;
                  dir_adv = DIR_UP;
               end else begin
                  acc_adv = acc_reg - step;
               end
            end
         end
         MODE_SQUARE: begin
            shape_val = sq_reg ? level : '0;
            sq_adv    = ~sq_reg;
         end
         MODE_MID: begin
            shape_val = MID_SCALE;
         end
         default: begin
            shape_val = '0;
         end
      endcase
   end

   // Next-state for divider, waveform state, handshake and overrun counter.
   always_comb begin
      cnt_next    = cnt_reg;
      mode_q_next = mode_q_reg;
      acc_next    = acc_reg;
      dir_next    = dir_reg;
      sq_next     = sq_reg;
      valid_next  = valid_reg;
      ovr_next    = ovr_reg;

      // Divider: natural wrap at all-ones covers a div lowered below count.
      if (mode_change || !en || cnt_at_div) begin
         cnt_next = '0;
      end else begin
         cnt_next = cnt_reg + 1'b1;
      end

      if (mode_change) begin
         mode_q_next = mode;
         acc_next    = '0;
         dir_next    = DIR_UP;
         sq_next     = 1'b0;
      end else if (accept) begin
         acc_next    = acc_adv;
         dir_next    = dir_adv;
         sq_next     = sq_adv;
      end

      if (accept) begin
         valid_next = 1'b1;
      end else if (handshake) begin
         valid_next = 1'b0;
      end

      if (drop && (ovr_reg != 8'hFF)) begin
         ovr_next = ovr_reg + 8'd1;
      end
   end

   // Control and waveform state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg    <= '0;
         mode_q_reg <= MODE_ZERO;
         acc_reg    <= '0;
         dir_reg    <= DIR_UP;
         sq_reg     <= 1'b0;
         valid_reg  <= 1'b0;
         ovr_reg    <= 8'd0;
      end else begin
         cnt_reg    <= cnt_next;
         mode_q_reg <= mode_q_next;
         acc_reg    <= acc_next;
         dir_reg    <= dir_next;
         sq_reg     <= sq_next;
         valid_reg  <= valid_next;
         ovr_reg    <= ovr_next;
      end
   end

   // One output lane per channel, each offset by its index times CH_OFFSET.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         localparam logic [DATA_W-1:0] CH_ADD = DATA_W'(gi) * CH_OFFSET;

         // Capture the offset sample on every accepted tick.
         always_ff @(posedge clk) begin
            if (reset) begin
               data_reg[gi] <= '0;
            end else if (accept) begin
               data_reg[gi] <= shape_val + CH_ADD;
            end
         end

         assign dac_if.dac_data[gi*DATA_W +: DATA_W] = data_reg[gi];
      end
   endgenerate

   assign dac_if.dac_valid = valid_reg;
   assign overrun_cnt      = ovr_reg;

endmodule

// File: tb/tb_dac_pattern_gen.sv
// Bench for dac_pattern_gen: directed scenarios followed by a randomized run,
// all compared each cycle against a behavioural sample-stream model.
module tb_dac_pattern_gen;

   logic        clk;
   logic        reset;
   logic        en;
   logic [2:0]  mode;
   logic [15:0] level;
   logic [15:0] step;
   logic [7:0]  div;
   logic        ready;
   logic [7:0]  overrun_cnt;

   int checks = 0;
   int errors = 0;

   dac_pattern_gen_if #(.NUM_CH(4), .DATA_W(16)) dac_bus ();
   assign dac_bus.dac_ready = ready;

   dac_pattern_gen #(
      .NUM_CH    (4),
      .DATA_W    (16),
      .DIV_W     (8),
      .CH_OFFSET (16'h0100)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .mode        (mode),
      .level       (level),
      .step        (step),
      .div         (div),
      .dac_if      (dac_bus),
      .overrun_cnt (overrun_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model state
   int m_cnt, m_mode_q, m_acc, m_ovr;
   bit m_up, m_sq, m_valid;
   int m_data [4];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model_word();
      logic [63:0] w;
      for (int k = 0; k < 4; k++) w[k*16 +: 16] = 16'(m_data[k]);
      return w;
   endfunction

   // One clock edge of the sample stream, written from the behaviour rules.
   task model_edge();
      bit hs, tick;
      int shp, st;
      if (reset) begin
         m_cnt = 0; m_mode_q = 0; m_acc = 0; m_up = 1; m_sq = 0;
         m_valid = 0; m_ovr = 0;
         for (int k = 0; k < 4; k++) m_data[k] = 0;
         return;
      end
      hs = m_valid && ready;
      if (int'(mode) != m_mode_q) begin
         m_mode_q = int'(mode); m_acc = 0; m_up = 1; m_sq = 0; m_cnt = 0;
         if (hs) m_valid = 0;
         return;
      end
      tick = en && (m_cnt == int'(div));
      if (!en || tick) m_cnt = 0;
      else m_cnt = (m_cnt + 1) % 256;
      if (tick && (!m_valid || ready)) begin
         st = int'(step);
         case (m_mode_q)
            1: shp = int'(level);
            2: shp = m_acc;
            3: shp = m_acc;
            4: shp = m_sq ? int'(level) : 0;
            5: shp = 32768;
            default: shp = 0;
         endcase
         for (int k = 0; k < 4; k++) m_data[k] = (shp + k * 256) % 65536;
         if (m_mode_q == 2) m_acc = (m_acc + st) % 65536;
         else if (m_mode_q == 3) begin
            if (m_up) begin
               if (m_acc + st > 65535) begin m_acc = 65535; m_up = 0; end
               else m_acc = m_acc + st;
            end else begin
               if (m_acc < st) begin m_acc = 0; m_up = 1; end
               else m_acc = m_acc - st;
            end
         end else if (m_mode_q == 4) m_sq = !m_sq;
         m_valid = 1;
      end else if (tick) begin
         if (m_ovr < 255) m_ovr++;
      end else if (hs) begin
         m_valid = 0;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check("valid", {63'd0, dac_bus.dac_valid}, {63'd0, m_valid});
      check("data", dac_bus.dac_data, model_word());
      check("overrun", {56'd0, overrun_cnt}, 64'(m_ovr));
   endtask

   task automatic run_sample(input int max_cyc, output int n, output logic [15:0] c0, output logic [15:0] c3);
      bit found;
      found = 0; n = 0; c0 = '0; c3 = '0;
      while (!found && n < max_cyc) begin
         cycle();
         n++;
         if (dac_bus.dac_valid === 1'b1) begin
            found = 1;
            c0 = dac_bus.dac_data[15:0];
            c3 = dac_bus.dac_data[63:48];
         end
      end
      check("sample_timeout", {63'd0, found}, 64'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      check("rst_valid", {63'd0, dac_bus.dac_valid}, 64'd0);
      check("rst_data", dac_bus.dac_data, 64'd0);
      check("rst_ovr", {56'd0, overrun_cnt}, 64'd0);
      reset = 1'b0;
   endtask

   logic [15:0] tri_exp [8] = '{16'h0000, 16'h6000, 16'hC000, 16'hFFFF,
                                16'h9FFF, 16'h3FFF, 16'h0000, 16'h6000};

   initial begin
      int n;
      logic [15:0] c0, c3;
      reset = 1'b1; en = 1'b0; mode = 3'd0; level = '0; step = '0; div = '0; ready = 1'b0;
      do_reset();

      // Sawtooth, one sample per four cycles, wraps after sixteen steps
      mode = 3'd2; step = 16'h1000; div = 8'd3; ready = 1'b1; en = 1'b1;
      for (int i = 0; i < 17; i++) begin
         run_sample(20, n, c0, c3);
         check("saw_value", 64'(c0), 64'((i * 16'h1000) % 65536));
         check("saw_period", 64'(n), (i == 0) ? 64'd5 : 64'd4);
         $display("saw sample %0d ch0=%h after %0d cycles", i, c0, n);
      end

      // Triangle with clamping at both ends
      mode = 3'd3; step = 16'h6000;
      for (int i = 0; i < 8; i++) begin
         run_sample(20, n, c0, c3);
         check("tri_value", 64'(c0), 64'(tri_exp[i]));
         $display("tri sample %0d ch0=%h", i, c0);
      end

      // Square with per-channel offset
      mode = 3'd4; level = 16'h8800;
      for (int i = 0; i < 4; i++) begin
         run_sample(20, n, c0, c3);
         check("sq_ch0", 64'(c0), (i % 2) ? 64'h8800 : 64'h0000);
         check("sq_ch3", 64'(c3), (i % 2) ? 64'h8B00 : 64'h0300);
         $display("square sample %0d ch0=%h ch3=%h", i, c0, c3);
      end

      // Stalled downstream: first sample held, later ticks counted then saturate
      do_reset();
      mode = 3'd1; level = 16'hFFFF; div = 8'd0; ready = 1'b0;
      for (int i = 0; i < 11; i++) cycle();
      check("stall_ch0", {48'd0, dac_bus.dac_data[15:0]}, 64'hFFFF);
      check("stall_ovr9", {56'd0, overrun_cnt}, 64'd9);
      $display("stall: ch0=%h overrun=%0d", dac_bus.dac_data[15:0], overrun_cnt);
      for (int i = 0; i < 300; i++) cycle();
      check("stall_ovr_sat", {56'd0, overrun_cnt}, 64'd255);
      $display("stall saturate: overrun=%0d", overrun_cnt);

      // Mode switch mid-period restarts the divider
      do_reset();
      mode = 3'd2; step = 16'h1000; div = 8'd5; ready = 1'b1;
      run_sample(20, n, c0, c3);
      run_sample(20, n, c0, c3);
      cycle(); cycle();
      mode = 3'd5;
      cycle();
      run_sample(20, n, c0, c3);
      check("mid_delay", 64'(n), 64'd6);
      check("mid_ch0", 64'(c0), 64'h8000);
      check("mid_ch3", 64'(c3), 64'h8300);
      $display("mode switch: sample ch0=%h ch3=%h after %0d cycles", c0, c3, n);

      // Reset while a sample is pending and the ramp is mid-way
      mode = 3'd2; step = 16'h1000; div = 8'd1;
      run_sample(20, n, c0, c3);
      ready = 1'b0;
      for (int i = 0; i < 6; i++) cycle();
      check("pend_valid", {63'd0, dac_bus.dac_valid}, 64'd1);
      do_reset();
      ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         run_sample(20, n, c0, c3);
         check("restart_value", 64'(c0), 64'(i * 16'h1000));
         $display("restart sample %0d ch0=%h", i, c0);
      end

      // div=0 with ready held: a fresh sample every cycle
      step = 16'h0001; div = 8'd0;
      mode = 3'd3;
      cycle();
      mode = 3'd2;
      cycle();
      for (int i = 0; i < 20; i++) begin
         cycle();
         check("cont_valid", {63'd0, dac_bus.dac_valid}, 64'd1);
         check("cont_value", {48'd0, dac_bus.dac_data[15:0]}, 64'(i));
      end
      check("cont_ovr", {56'd0, overrun_cnt}, 64'd0);
      $display("continuous: last ch0=%h", dac_bus.dac_data[15:0]);

      // Lowering div below the running count gives one long period
      mode = 3'd0; cycle();
      mode = 3'd2; div = 8'd10;
      cycle();
      for (int i = 0; i < 8; i++) cycle();
      div = 8'd3;
      run_sample(400, n, c0, c3);
      check("long_period", 64'(n), 64'd252);
      $display("div lowered: sample after %0d cycles", n);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         ready = ($urandom_range(0, 3) != 0);
         en    = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 39) == 0) mode = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 59) == 0) div = 8'($urandom_range(0, 6));
         if ($urandom_range(0, 49) == 0) step = 16'($urandom);
         if ($urandom_range(0, 49) == 0) level = 16'($urandom);
         reset = ($urandom_range(0, 499) == 0);
         cycle();
      end
      reset = 1'b0;
      $display("random phase done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dac_pattern_gen.md
# dac_pattern_gen

Parametrised multi-channel DAC sample source that replaces fixed switch-selected levels with timed waveforms. It produces one NUM_CH-wide sample word per update tick (static level, sawtooth, triangle, square or mid-scale) with a per-channel offset. Each word is offered to the downstream DAC serial interface through a valid/ready handshake. It sits between board-level mode control and the SPI DAC interface instances.

## Interface
- NUM_CH, 4: number of DAC channels packed in dac_data.
- DATA_W, 16: sample width per channel.
- DIV_W, 16: width of update-period divider.
- CH_OFFSET, 0: value added to channel k sample as k*CH_OFFSET, modulo 2^DATA_W.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  enables tick generation; low freezes the block (handshake still completes).
- mode  in  3  waveform select; already synchronised to clk.
- level  in  DATA_W  static level / square high value.
- step  in  DATA_W  ramp/triangle increment per tick.
- div  in  DIV_W  update period = div+1 clk cycles.
- dac_data  out  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
- dac_valid  out  1  dac_data holds an unconsumed sample.
- dac_ready  in  1  downstream accepts when dac_valid && dac_ready.
- overrun_cnt  out  8  saturating count of dropped ticks.

## Operation
- Reset values: dac_data 0, dac_valid 0, overrun_cnt 0; internal acc 0, dir up, sq 0, tick counter 0, mode_q 0.
- Tick counter: counts 0..div while en=1; tick asserted in the cycle count==div, counter then wraps to 0. en=0 holds counter at 0, no ticks.
- Mode change: when mode != mode_q, mode_q <= mode, acc <= 0, dir <= up, sq <= 0, counter <= 0; no tick in that cycle; pending dac_valid/dac_data untouched.
- On tick with dac_valid=0, or dac_valid=1 && dac_ready=1 in the same cycle: base <= shape(acc), then acc advances; dac_data channel k <= base + k*CH_OFFSET (mod 2^DATA_W); dac_valid <= 1.
- On tick with dac_valid=1 && dac_ready=0: sample dropped, acc/dir/sq unchanged, overrun_cnt += 1 saturating at 255.
- Handshake with no tick: dac_valid <= 0; dac_data holds last value.
- Modes (shape / advance):
  - 0: 0 / none.
  - 1: level / none.
  - 2 sawtooth: acc / acc+step, wraps mod 2^DATA_W.
  - 3 triangle: acc / up: if acc > MAX-step then acc<=MAX, dir<=down else acc+=step; down: if acc < step then acc<=0, dir<=up else acc-=step. MAX = 2^DATA_W-1.
  - 4 square: (sq ? level : 0) / sq toggles.
  - 5: 2^(DATA_W-1) (mid-scale) / none.
  - 6,7: treated as 0.
- step=0 in modes 2/3: constant output 0, still ticks and handshakes.
- div or level changes take effect immediately; div lowered below current count: counter continues to its max (2^DIV_W-1) and wraps to 0 with no intermediate tick, so one long period occurs.

## Timing
- Tick in cycle t -> dac_data/dac_valid updated at edge ending t, visible cycle t+1.
- div=0 with dac_ready held 1: new sample every cycle, dac_valid continuously 1, no overruns.
- dac_valid deasserts the cycle after a handshake unless a tick coincides.
- Reset mid-operation: all state returns to reset values at the next edge regardless of en/handshake.
- First sample after reset for any mode is shape(0-state): 0 for modes 0,2,3,4.

## Test plan
- Reset, mode=2, step=0x1000, div=3, ready=1, en=1 -> dac_valid pulses every 4 cycles; ch0 = 0x0000,0x1000,...,0xF000,0x0000 (wrap).
- mode=3, step=0x6000, DATA_W=16 -> ch0 = 0x0000,0x6000,0xC000,0xFFFF,0x9FFF,0x3FFF,0x0000,0x6000.
- mode=4, level=0x8800, CH_OFFSET=0x0100, NUM_CH=4 -> ch0 alternates 0x0000/0x8800; ch3 alternates 0x0300/0x8B00.
- mode=1 level=0xFFFF, div=0, ready=0 for 10 cycles -> first sample held, overrun_cnt=9; after 300 stalled ticks overrun_cnt=255.
- Mode 2 running, switch to mode=5 mid-period -> counter restarts; next sample 0x8000 exactly div+1 cycles after change.
- Assert reset while dac_valid=1 and acc nonzero -> next cycle dac_valid=0, dac_data=0, overrun_cnt=0; ramp restarts at 0x0000.
